// File: rtl/recv_bcd_frame.sv
// Assembles a LF-terminated frame of ASCII digits from uart_rx into a packed BCD word, committed atomically.
// Outputs registered (pulses one cycle after rx_done); no backpressure. Define RECV_HEX_EN to also accept A-F/a-f.
module recv_bcd_frame #(
    parameter int          DIGITS         = 8,
    parameter logic [7:0]  TERM_CHAR      = 8'h0A,
    parameter logic [7:0]  IGNORE_CHAR    = 8'h0D,
    parameter int          TIMEOUT_CYCLES = 5000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_done,
    output logic [4*DIGITS-1:0]          bcd_out,
    output logic                         frame_valid,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic                         busy
);

    localparam int W     = 4 * DIGITS;
    localparam int CW    = $clog2(DIGITS + 1);
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TLAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ERR_BAD  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    bcd_d;
    logic [CW-1:0]   cnt_d;
    logic [1:0]      ec_d;
    logic            fv_d, fe_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [4:0]      dec;
    logic            byte_ev, is_term, timeout_hit;

    // Returns {is_digit, nibble}.
    function automatic logic [4:0] decode(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
`ifdef RECV_HEX_EN
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            r = {1'b1, b[3:0] + 4'd9};
`endif
        return r;
    endfunction

    always_comb begin
        dec         = decode(rx_data);
        byte_ev     = rx_done && (rx_data != IGNORE_CHAR);
        is_term     = (rx_data == TERM_CHAR);
        // A byte arriving on the expiry cycle wins over the timeout.
        timeout_hit = TO_EN && (state_q != IDLE) && !rx_done && (tcnt_q == TLAST);

        state_d  = state_q;
        shadow_d = shadow_q;
        bcd_d    = bcd_out;
        cnt_d    = digit_cnt;
        ec_d     = err_code;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        tcnt_d   = tcnt_q;

        if (!TO_EN || byte_ev || state_q == IDLE || timeout_hit)
            tcnt_d = '0;
        else if (tcnt_q != TLAST)
            tcnt_d = tcnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (byte_ev && !is_term) begin
                    if (dec[4]) begin
                        shadow_d = W'(dec[3:0]);
                        cnt_d    = CW'(1);
                        state_d  = COLLECT;
                    end else begin
                        fe_d    = 1'b1;
                        ec_d    = ERR_BAD;
                        state_d = DISCARD;
                    end
                end
            end
            COLLECT: begin
                if (byte_ev) begin
                    if (is_term) begin
                        bcd_d   = shadow_q;
                        fv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (dec[4]) begin
                        if (digit_cnt < CW'(DIGITS)) begin
                            shadow_d = (shadow_q << 4) | W'(dec[3:0]);
                            cnt_d    = digit_cnt + 1'b1;
                        end else begin
                            fe_d    = 1'b1;
                            ec_d    = ERR_OVF;
                            state_d = DISCARD;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        ec_d    = ERR_BAD;
                        state_d = DISCARD;
                    end
                end else if (timeout_hit) begin
                    fe_d    = 1'b1;
                    ec_d    = ERR_TOUT;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if ((byte_ev && is_term) || timeout_hit) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            bcd_out     <= '0;
            digit_cnt   <= '0;
            err_code    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            bcd_out     <= bcd_d;
            digit_cnt   <= cnt_d;
            err_code    <= ec_d;
            frame_valid <= fv_d;
            frame_err   <= fe_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_recv_bcd_frame.sv
// Bench for recv_bcd_frame: directed vector table, hand-written timeout/reset sequences, then random frames vs a digit-list model.
module tb_recv_bcd_frame;

    localparam int DIGITS = 8;
    localparam int TO     = 100;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [31:0] bcd_out;
    logic        frame_valid, frame_err, busy;
    logic [1:0]  err_code;
    logic [3:0]  digit_cnt;

    always #5 clk = ~clk;

    recv_bcd_frame #(
        .DIGITS(DIGITS), .TERM_CHAR(LF), .IGNORE_CHAR(CR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .bcd_out(bcd_out), .frame_valid(frame_valid), .frame_err(frame_err),
        .err_code(err_code), .digit_cnt(digit_cnt), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: list of received digit values plus frame mode flags.
    int          digs[$];
    bit          m_col, m_dis;
    int          silence;
    logic [31:0] m_bcd;
    bit          m_fv, m_fe;
    logic [1:0]  m_ec;

    function automatic int dig_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 'h30;
`ifdef RECV_HEX_EN
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 'h41 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 'h61 + 10;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        digs.delete();
        m_col = 0; m_dis = 0; silence = 0;
        m_bcd = '0; m_fv = 0; m_fe = 0; m_ec = '0;
    endtask

    task automatic model_step(input bit d, input logic [7:0] b);
        int v;
        logic [31:0] val;
        m_fv = 0;
        m_fe = 0;
        if (d && b != CR) begin
            silence = 0;
            v = dig_val(b);
            if (m_dis) begin
                if (b == LF) begin m_dis = 0; digs.delete(); end
            end else if (m_col) begin
                if (b == LF) begin
                    val = '0;
                    foreach (digs[i]) val = (val << 4) | 32'(digs[i]);
                    m_bcd = val; m_fv = 1; m_col = 0; digs.delete();
                end else if (v >= 0) begin
                    if (digs.size() < DIGITS) digs.push_back(v);
                    else begin m_fe = 1; m_ec = 2'b10; m_col = 0; m_dis = 1; end
                end else begin
                    m_fe = 1; m_ec = 2'b01; m_col = 0; m_dis = 1;
                end
            end else if (b != LF) begin
                if (v >= 0) begin digs.push_back(v); m_col = 1; end
                else begin m_fe = 1; m_ec = 2'b01; m_dis = 1; end
            end
        end else if (m_col || m_dis) begin
            if (!d && silence >= TO - 1) begin
                if (m_col) begin m_fe = 1; m_ec = 2'b11; end
                m_col = 0; m_dis = 0; digs.delete(); silence = 0;
            end else begin
                silence++;
            end
        end
    endtask

    task automatic check_model();
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_err",   32'(frame_err),   32'(m_fe));
        chk("err_code",    32'(err_code),    32'(m_ec));
        chk("bcd_out",     bcd_out,          m_bcd);
        chk("digit_cnt",   32'(digit_cnt),   32'(digs.size()));
        chk("busy",        32'(busy),        32'(m_col || m_dis));
    endtask

    // One clock: drive at a falling edge, check at the next falling edge.
    task automatic cycle(input bit d, input logic [7:0] b);
        rx_done = d;
        rx_data = b;
        model_step(d, b);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        fv;
        logic        fe;
        logic [1:0]  ec;
        logic [31:0] bcd;
        logic [3:0]  cnt;
        logic        busy;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [7:0] data, input logic fv, input logic fe, input logic [1:0] ec,
                       input logic [31:0] bcd, input logic [3:0] cnt, input logic bz);
        vec_t e;
        e.data = data; e.fv = fv; e.fe = fe; e.ec = ec; e.bcd = bcd; e.cnt = cnt; e.busy = bz;
        tbl.push_back(e);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) return 8'(8'h30 + $urandom_range(0, 9));
        if (r < 78) return CR;
        if (r < 84) return ($urandom_range(0, 1) == 0) ? 8'(8'h61 + $urandom_range(0, 5))
                                                        : 8'(8'h41 + $urandom_range(0, 5));
        if (r < 92) return 8'(8'h20 + $urandom_range(0, 15));
        return LF;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_bcd",  bcd_out, 32'h0);
        chk("rst_fv",   32'(frame_valid), 0);
        chk("rst_fe",   32'(frame_err), 0);
        chk("rst_ec",   32'(err_code), 0);
        chk("rst_cnt",  32'(digit_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        add(8'h31, 0, 0, 2'd0, 32'h0,   1, 1);
        add(8'h32, 0, 0, 2'd0, 32'h0,   2, 1);
        add(8'h33, 0, 0, 2'd0, 32'h0,   3, 1);
        add(LF,    1, 0, 2'd0, 32'h123, 0, 0);
        add(8'h31, 0, 0, 2'd0, 32'h123, 1, 1);
        add(8'h58, 0, 1, 2'd1, 32'h123, 1, 1);
        add(8'h35, 0, 0, 2'd1, 32'h123, 1, 1);
        add(LF,    0, 0, 2'd1, 32'h123, 0, 0);
        add(8'h39, 0, 0, 2'd1, 32'h123, 1, 1);
        add(8'h38, 0, 0, 2'd1, 32'h123, 2, 1);
        add(CR,    0, 0, 2'd1, 32'h123, 2, 1);
        add(LF,    1, 0, 2'd1, 32'h98,  0, 0);
        for (int k = 1; k <= 8; k++) add(8'(8'h30 + k), 0, 0, 2'd1, 32'h98, 4'(k), 1);
        add(8'h39, 0, 1, 2'd2, 32'h98, 8, 1);
        add(LF,    0, 0, 2'd2, 32'h98, 0, 0);
        add(LF,    0, 0, 2'd2, 32'h98, 0, 0);
        add(8'h5A, 0, 1, 2'd1, 32'h98, 0, 1);
        add(LF,    0, 0, 2'd1, 32'h98, 0, 0);

        foreach (tbl[i]) begin
            rx_done = 1'b1;
            rx_data = tbl[i].data;
            model_step(1'b1, tbl[i].data);
            @(negedge clk);
            chk($sformatf("tbl%0d_fv", i),   32'(frame_valid), 32'(tbl[i].fv));
            chk($sformatf("tbl%0d_fe", i),   32'(frame_err),   32'(tbl[i].fe));
            chk($sformatf("tbl%0d_ec", i),   32'(err_code),    32'(tbl[i].ec));
            chk($sformatf("tbl%0d_bcd", i),  bcd_out,          tbl[i].bcd);
            chk($sformatf("tbl%0d_cnt", i),  32'(digit_cnt),   32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy),        32'(tbl[i].busy));
        end
        cycle(1'b0, 8'h00);

        // Timeout after exactly TO silent cycles, then a fresh frame.
        cycle(1'b1, 8'h34);
        repeat (TO - 1) cycle(1'b0, 8'h00);
        chk("to_early_fe", 32'(frame_err), 0);
        cycle(1'b0, 8'h00);
        chk("to_fe", 32'(frame_err), 1);
        chk("to_ec", 32'(err_code), 3);
        chk("to_busy", 32'(busy), 0);
        cycle(1'b1, 8'h37);
        cycle(1'b1, LF);
        chk("to_next_bcd", bcd_out, 32'h7);

        // Byte on the expiry cycle wins.
        cycle(1'b1, 8'h34);
        repeat (TO - 1) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h35);
        chk("coin_fe", 32'(frame_err), 0);
        chk("coin_cnt", 32'(digit_cnt), 2);
        cycle(1'b1, LF);
        chk("coin_bcd", bcd_out, 32'h45);

        // CR on the expiry cycle only delays the timeout.
        cycle(1'b1, 8'h36);
        repeat (TO - 1) cycle(1'b0, 8'h00);
        cycle(1'b1, CR);
        chk("cr_to_fe0", 32'(frame_err), 0);
        cycle(1'b0, 8'h00);
        chk("cr_to_fe1", 32'(frame_err), 1);

        // Timeout from DISCARD is silent.
        cycle(1'b1, 8'h58);
        repeat (TO) cycle(1'b0, 8'h00);
        chk("dis_to_busy", 32'(busy), 0);
        chk("dis_to_fe", 32'(frame_err), 0);

        cycle(1'b1, 8'h61);
`ifdef RECV_HEX_EN
        chk("hex_a_fe", 32'(frame_err), 0);
`else
        chk("hex_a_fe", 32'(frame_err), 1);
        chk("hex_a_ec", 32'(err_code), 1);
`endif
        cycle(1'b1, 8'h46);
        cycle(1'b1, 8'h30);
        cycle(1'b1, LF);
`ifdef RECV_HEX_EN
        chk("hex_fv", 32'(frame_valid), 1);
        chk("hex_bcd", bcd_out, 32'hAF0);
`else
        chk("hex_fv", 32'(frame_valid), 0);
        chk("hex_bcd", bcd_out, 32'h45);
`endif

        // Reset in the middle of a frame.
        cycle(1'b1, 8'h33);
        rx_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_bcd", bcd_out, 32'h0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_cnt", 32'(digit_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 8'h32);
        cycle(1'b1, LF);
        chk("mrst_next_bcd", bcd_out, 32'h2);

        for (int f = 0; f < 300; f++) begin
            int gap;
            int len;
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(90, 110)) : int'($urandom_range(0, 3));
            repeat (gap) cycle(1'b0, 8'h00);
            len = int'($urandom_range(0, 11));
            for (int j = 0; j < len; j++) begin
                cycle(1'b1, rand_byte());
                repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00);
            end
            if ($urandom_range(0, 4) != 0) cycle(1'b1, LF);
        end
        cycle(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
